// File: rtl/q_ctrl_pkg.sv
// Shared types and constants for the Q control loop.
// Used by the controller and the measurement frontend.
package q_ctrl_pkg;

    localparam int DEF_WIDTH        = 10;
    localparam int DEF_LOG2_SAMPLES = 4;
    localparam int ACC_W            = DEF_WIDTH + DEF_LOG2_SAMPLES;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM
    } state_t;

    // Sum of 2^l samples of w bits each always fits in w+l bits
    function automatic int acc_w_of(input int w, input int l);
        return w + l;
    endfunction

endpackage

// File: rtl/q_meas_frontend_if.sv
// Controller / ADC / DAC signal bundle of the measurement frontend.
// The frontend takes the slave side.
interface q_meas_frontend_if #(
    parameter int WIDTH = q_ctrl_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] i_ref;
    logic             adc_valid;
    logic [WIDTH-1:0] adc_data;
    logic [WIDTH-1:0] i_drive;
    logic [WIDTH-1:0] q_meas;
    logic             ready;
    logic             busy;
    logic             timeout;

    modport master (
        output start, i_ref, adc_valid, adc_data,
        input  i_drive, q_meas, ready, busy, timeout
    );

    modport slave (
        input  start, i_ref, adc_valid, adc_data,
        output i_drive, q_meas, ready, busy, timeout
    );

endinterface

// File: rtl/q_meas_frontend_avg.sv
// Sample accumulator with power-of-two averaging.
// done flags that the next accepted sample completes the set.
module sample_averager
    import q_ctrl_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LOG2_SAMPLES = DEF_LOG2_SAMPLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample,
    input  logic [WIDTH-1:0] data,
    output logic             done,
    output logic [WIDTH-1:0] avg
);

    localparam int AW = acc_w_of(WIDTH, LOG2_SAMPLES);
    localparam int CW = LOG2_SAMPLES + 1;
    localparam int N  = 2 ** LOG2_SAMPLES;

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign acc_nxt = acc + AW'(data);
    assign cnt_inc = cnt + CW'(1);
    assign done    = (cnt == CW'(N - 1));
    // Average includes the sample presented this cycle
    assign avg     = WIDTH'(acc_nxt >> LOG2_SAMPLES);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (sample) begin
            acc <= acc_nxt;
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/q_meas_frontend.sv
// Q measurement frontend: drive DAC, settle, average ADC samples.
// Aborts with a timeout pulse if the ADC goes quiet while sampling.
module q_meas_frontend
    import q_ctrl_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int SETTLE_CYCLES  = 64,
    parameter int LOG2_SAMPLES   = DEF_LOG2_SAMPLES,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    q_meas_frontend_if.slave   bus
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state, state_nxt;
    logic [SW-1:0]    settle_cnt, settle_nxt;
    logic [TW-1:0]    idle_cnt, idle_nxt;
    logic             accept, smp, done;
    logic             fire_ready, fire_to;
    logic [WIDTH-1:0] avg;
    logic [WIDTH-1:0] i_drive_q, q_meas_q;
    logic             ready_q, timeout_q;

    sample_averager #(
        .WIDTH        (WIDTH),
        .LOG2_SAMPLES (LOG2_SAMPLES)
    ) u_avg (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .sample (smp),
        .data   (bus.adc_data),
        .done   (done),
        .avg    (avg)
    );

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        idle_nxt   = idle_cnt;
        accept     = 1'b0;
        smp        = 1'b0;
        fire_ready = 1'b0;
        fire_to    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    settle_nxt = SW'(SETTLE_CYCLES);
                    idle_nxt   = '0;
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                settle_nxt = settle_cnt - SW'(1);
                if (settle_cnt == SW'(1))
                    state_nxt = ACCUM;
            end
            ACCUM: begin
                // A sample in the would-be timeout cycle takes priority
                if (bus.adc_valid) begin
                    smp      = 1'b1;
                    idle_nxt = '0;
                    if (done) begin
                        fire_ready = 1'b1;
                        state_nxt  = IDLE;
                    end
                end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    fire_to   = 1'b1;
                    idle_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    idle_nxt = idle_cnt + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            idle_cnt   <= '0;
            i_drive_q  <= '0;
            q_meas_q   <= '0;
            ready_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            idle_cnt   <= idle_nxt;
            ready_q    <= fire_ready;
            timeout_q  <= fire_to;
            if (accept)
                i_drive_q <= bus.i_ref;
            if (fire_ready)
                q_meas_q <= avg;
        end
    end

    assign bus.i_drive = i_drive_q;
    assign bus.q_meas  = q_meas_q;
    assign bus.ready   = ready_q;
    assign bus.timeout = timeout_q;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_q_meas_frontend.sv
// Scoreboard bench for q_meas_frontend with a transaction-level model.
// Driver predicts each measurement outcome; monitor checks DUT events.
module tb_q_meas_frontend;
    import q_ctrl_pkg::*;

    localparam int W  = 10;
    localparam int S  = 4;
    localparam int L  = 2;
    localparam int T  = 8;
    localparam int NS = 1 << L;

    typedef struct {
        bit is_to;
        int val;
        int at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    q_meas_frontend_if #(.WIDTH(W)) bus ();

    q_meas_frontend #(
        .WIDTH          (W),
        .SETTLE_CYCLES  (S),
        .LOG2_SAMPLES   (L),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   q_model = 0;
    int   drive_model = 0;
    int   fixed_q[$];
    bit   vq[$];
    int   dq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every ready/timeout must match the oldest prediction
    always @(negedge clk) begin
        if (!rst && (bus.ready || bus.timeout)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", int'({bus.ready, bus.timeout}), 0);
            end else begin
                me = exp_q.pop_front();
                chk("ready", int'(bus.ready), int'(!me.is_to));
                chk("timeout", int'(bus.timeout), int'(me.is_to));
                chk("q_meas", int'(bus.q_meas), me.val);
                chk("event_cycle", cyc, me.at);
                chk("busy_at_event", int'(bus.busy), 0);
            end
        end
    end

    // mode 0 random, 1 valid every cycle, 2 valid only while settling,
    // 3 fixed_q after settle, 4 random data once every T cycles
    task automatic measure(input int iref, input int mode);
        int   len, sum, n, idle, off, s0, val;
        bit   to;
        exp_t e;
        vq.delete();
        dq.delete();
        len = S + 1 + 40;
        for (int k = 0; k < len; k++) begin
            bit v;
            int d;
            d = int'($urandom_range(0, (1 << W) - 1));
            case (mode)
                0: v = ($urandom_range(0, 1) == 1);
                1: v = 1'b1;
                2: v = (k <= S);
                3: begin
                    v = (k > S) && (k - S - 1 < fixed_q.size());
                    if (v) d = fixed_q[k - S - 1];
                end
                default: v = (k > S) && ((k - S - 1) % T == 0);
            endcase
            vq.push_back(v);
            dq.push_back(d);
        end
        sum  = 0;
        n    = 0;
        idle = 0;
        off  = -1;
        to   = 1'b0;
        val  = 0;
        for (int k = S + 1; k < len && off < 0; k++) begin
            if (vq[k]) begin
                sum += dq[k];
                n++;
                idle = 0;
                if (n == NS) begin
                    off = k;
                    to  = 1'b0;
                    val = sum / NS;
                end
            end else begin
                idle++;
                if (idle == T) begin
                    off = k;
                    to  = 1'b1;
                    val = q_model;
                end
            end
        end
        for (int k = 0; k <= off; k++) begin
            @(negedge clk);
            if (k == 0) begin
                s0      = cyc + 1;
                e.is_to = to;
                e.val   = val;
                e.at    = s0 + off;
                exp_q.push_back(e);
            end
            if (k == 1) begin
                chk("i_drive", int'(bus.i_drive), iref);
                chk("busy", int'(bus.busy), 1);
            end
            bus.start     = (k == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            bus.i_ref     = (k == 0) ? W'(iref) : W'($urandom_range(0, 1023));
            bus.adc_valid = vq[k];
            bus.adc_data  = W'(dq[k]);
        end
        drive_model = iref;
        if (!to) q_model = val;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.i_ref     = W'($urandom_range(0, 1023));
            bus.adc_valid = ($urandom_range(0, 1) == 1);
            bus.adc_data  = W'($urandom_range(0, 1023));
        end
        chk("i_drive_hold", int'(bus.i_drive), drive_model);
        chk("busy_idle", int'(bus.busy), 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.i_ref     = '0;
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_i_drive", int'(bus.i_drive), 0);
        chk("rst_q_meas", int'(bus.q_meas), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_timeout", int'(bus.timeout), 0);

        fixed_q = '{100, 101, 102, 104};
        measure(300, 3);
        gap(3);
        measure(123, 1);
        gap(2);
        measure(77, 2);
        gap(2);
        measure(211, 4);
        gap(1);
        measure(400, 0);
        measure(500, 1);
        gap(2);
        for (int i = 0; i < 20; i++) begin
            measure(int'($urandom_range(0, 1023)), int'($urandom_range(0, 4)) % 3 == 2 ? 2 : int'($urandom_range(0, 1)) * 4);
            if ($urandom_range(0, 1) == 1) gap(int'($urandom_range(1, 3)));
        end
        gap(2);

        @(negedge clk);
        bus.start     = 1'b1;
        bus.i_ref     = W'(321);
        bus.adc_valid = 1'b0;
        for (int k = 1; k <= S + 2; k++) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.adc_valid = (k > S);
            bus.adc_data  = (k == S + 1) ? W'(700) : W'(900);
        end
        @(negedge clk);
        rst           = 1'b1;
        bus.adc_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_i_drive", int'(bus.i_drive), 0);
        chk("mid_rst_q_meas", int'(bus.q_meas), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_ready", int'(bus.ready), 0);
        chk("mid_rst_timeout", int'(bus.timeout), 0);
        q_model     = 0;
        drive_model = 0;
        gap(2);

        fixed_q = '{1023, 1023, 1023, 1023};
        measure(1023, 3);
        gap(2);
        measure(9, 2);
        gap(4);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
